// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the data-memory responder:
//                FSM state encoding, lane geometry and error-bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BYTE_LANES = 4;
    localparam int WORD_BYTES = 4;

    // Bit positions inside the internal error vector (also visible to debug)
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_W        = 2;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_word_array
//  Description : Single-port synchronous word RAM with per-byte write enables
//                and a registered read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [BYTE_LANES-1:0] be_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // One access per cycle: lane-masked write, otherwise a registered read
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BYTE_LANES; b++) begin
                    if (be_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : mem_word_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Word-organised data-memory target with a valid/ready
//                request/response handshake and fixed latency. One request
//                outstanding at a time; sub-word stores via byte enables;
//                misaligned or out-of-range accesses answer with resp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              req_wr,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rerr_q, rerr_d;

    // Request captured at accept; no reset needed, only meaningful in WAIT
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;
    logic              wr_q;
    logic [3:0]        be_q;
    logic [ERR_W-1:0]  err_q;

    logic [ADDR_W-1:0] req_word;
    logic [ERR_W-1:0]  req_err;
    logic              accept;
    logic              commit;
    logic              arr_en;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_idx;
    logic [31:0]       arr_rdata;

    assign req_word              = ADDR_W'(req_addr[ADDR_W-1:2]);
    assign req_err[ERR_MISALIGN] = |req_addr[1:0];
    assign req_err[ERR_RANGE]    = (req_word >= ADDR_W'(DEPTH_WORDS));

    assign accept = req_valid && (state_q == IDLE);
    assign commit = (state_q == WAIT) && (cnt_q == 4'd0);

    // The array is read at the accept edge and refreshed while waiting, so the
    // registered read data is already settled when the commit edge samples it.
    assign arr_idx = (state_q == IDLE) ? req_addr[IDX_W+1:2] : idx_q;
    assign arr_en  = (accept && !(|req_err)) || ((state_q == WAIT) && !(|err_q));
    assign arr_we  = commit && wr_q && !(|err_q);

    mem_word_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .en_i    (arr_en),
        .we_i    (arr_we),
        .be_i    (be_q),
        .idx_i   (arr_idx),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    // Capture the request fields on the accept edge
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
            wr_q    <= req_wr;
            be_q    <= req_be;
            err_q   <= req_err;
        end
    end

    // Next-state, latency countdown and response data
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    rerr_d  = |err_q;
                    rdata_d = (!wr_q && !(|err_q)) ? arr_rdata : 32'h0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'h0;
                    rerr_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and response registers; reset drops any request in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. Instance A uses
//                LATENCY=2, instance B uses LATENCY=1 with back-to-back
//                requests. Expected responses come from a reference memory
//                model through per-instance scoreboard queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_req_valid, a_req_ready, a_req_wr, a_resp_valid, a_resp_ready, a_resp_err, a_busy;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [3:0]  a_req_be;
    logic        b_req_valid, b_req_ready, b_req_wr, b_resp_valid, b_resp_ready, b_resp_err, b_busy;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_req_be;

    mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_wr(a_req_wr), .req_be(a_req_be),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .busy(a_busy)
    );

    mem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_wr(b_req_wr), .req_be(b_req_be),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .busy(b_busy)
    );

    int          nvec = 0;
    int          nmis = 0;
    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    logic [32:0] sb_a [$];   // {err, rdata}
    logic [32:0] sb_b [$];
    int          b_gap = 0;

    // Cycles during which instance B refuses requests
    always @(negedge clk) if (!b_req_ready) b_gap++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    endfunction

    // Reference model: update storage and push the expected response
    task automatic predict(input bit inst_b, input logic [31:0] addr, input logic [31:0] wd,
                           input logic wr, input logic [3:0] be);
        logic [31:0] w;
        int          idx;
        logic [32:0] exp;
        idx = int'(addr[31:2]);
        if (bad_addr(addr)) begin
            exp = {1'b1, 32'h0};
        end else if (wr) begin
            w = 32'h0;
            if (!inst_b && mem_a.exists(idx)) w = mem_a[idx];
            if (inst_b && mem_b.exists(idx))  w = mem_b[idx];
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            if (inst_b) mem_b[idx] = w; else mem_a[idx] = w;
            exp = {1'b0, 32'h0};
        end else begin
            w = 32'h0;
            if (!inst_b && mem_a.exists(idx)) w = mem_a[idx];
            if (inst_b && mem_b.exists(idx))  w = mem_b[idx];
            exp = {1'b0, w};
        end
        if (inst_b) sb_b.push_back(exp); else sb_a.push_back(exp);
    endtask

    // One complete transaction on instance A; call #1 after a rising edge
    task automatic txn_a(input logic [31:0] addr, input logic [31:0] wd, input logic wr,
                         input logic [3:0] be, input int hold, input string tag,
                         output logic [31:0] rd);
        int          guard;
        int          lat;
        logic [32:0] held;
        logic [32:0] exp;
        a_req_addr = addr; a_req_wdata = wd; a_req_wr = wr; a_req_be = be; a_req_valid = 1'b1;
        guard = 0;
        while (!a_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        chk({tag, "_rdy"}, 64'(a_req_ready), 64'd1);
        @(posedge clk);
        predict(1'b0, addr, wd, wr, be);
        #1;
        a_req_valid = 1'b0; a_req_addr = 32'hFFFF_FFFF; a_req_wdata = $urandom; a_req_wr = ~wr;
        lat = 0;
        while (!a_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk({tag, "_lat"}, 64'(lat), 64'(LAT_A));
        held = {a_resp_err, a_resp_rdata};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, {a_resp_valid, a_req_ready, a_resp_err, a_resp_rdata},
                {1'b1, 1'b0, held});
        end
        exp = (sb_a.size() > 0) ? sb_a.pop_front() : 33'h1_FFFF_FFFF;
        chk({tag, "_resp"}, {a_resp_err, a_resp_rdata}, exp);
        rd = a_resp_rdata;
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        chk({tag, "_idle"}, {a_resp_valid, a_req_ready, a_busy, a_resp_err, a_resp_rdata},
            {1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, nvec=%0d", nvec);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] rd;
        logic [31:0] b_addr [5] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h42};
        logic [31:0] b_wd   [5] = '{32'h1234_5678, 32'h0, 32'hAABB_CCDD, 32'h0, 32'h0};
        logic        b_wr   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0]  b_be   [5] = '{4'hF, 4'h0, 4'b1100, 4'h0, 4'h0};
        int          lat;
        int          guard;
        logic [32:0] exp;

        rst = 1'b1;
        a_req_valid = 0; a_req_addr = 0; a_req_wdata = 0; a_req_wr = 0; a_req_be = 0; a_resp_ready = 0;
        b_req_valid = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wr = 0; b_req_be = 0; b_resp_ready = 0;
        #12;
        chk("reset_a", {a_req_ready, a_resp_valid, a_busy, a_resp_err, a_resp_rdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        chk("reset_b", {b_req_ready, b_resp_valid, b_busy, b_resp_err, b_resp_rdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Full-word store, then load it back
        txn_a(32'h10, 32'hDEAD_BEEF, 1'b1, 4'hF, 0, "st10", rd);
        txn_a(32'h10, 32'h0, 1'b0, 4'h0, 0, "ld10", rd);
        chk("ld10_const", rd, 32'hDEAD_BEEF);

        // Sub-word store on lanes 0 and 2
        txn_a(32'h10, 32'h1122_3344, 1'b1, 4'b0101, 0, "st10_be", rd);
        txn_a(32'h10, 32'h0, 1'b0, 4'h0, 0, "ld10_be", rd);
        chk("ld10_be_const", rd, 32'hDE22_BE44);

        // Misaligned and out-of-range accesses
        txn_a(32'h12, 32'h0, 1'b0, 4'h0, 0, "ld_mis", rd);
        txn_a(32'h1000, 32'h0, 1'b0, 4'h0, 0, "ld_oor", rd);
        txn_a(32'h12, 32'hAABB_CCDD, 1'b1, 4'hF, 0, "st_mis", rd);

        // Stalled response: held 3 cycles with resp_ready low
        txn_a(32'h10, 32'h0, 1'b0, 4'h0, 3, "ld10_hold", rd);
        chk("ld10_hold_const", rd, 32'hDE22_BE44);

        // Seed 0x20, then an empty-lane store that must not change it
        txn_a(32'h20, 32'h0123_4567, 1'b1, 4'hF, 0, "st20", rd);
        txn_a(32'h20, 32'hFFFF_FFFF, 1'b1, 4'h0, 0, "st20_be0", rd);

        // Reset while a store waits: the store must be dropped
        a_req_addr = 32'h20; a_req_wdata = 32'hCAFE_F00D; a_req_wr = 1'b1; a_req_be = 4'hF;
        a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        chk("wait_busy", {a_busy, a_req_ready}, {1'b1, 1'b0});
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {a_req_ready, a_resp_valid, a_busy, a_resp_err, a_resp_rdata},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        txn_a(32'h20, 32'h0, 1'b0, 4'h0, 0, "ld20", rd);
        chk("ld20_const", rd, 32'h0123_4567);

        // Instance B: requests held valid back to back, response always taken
        b_resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b_req_addr = b_addr[k]; b_req_wdata = b_wd[k]; b_req_wr = b_wr[k]; b_req_be = b_be[k];
            b_req_valid = 1'b1;
            guard = 0;
            while (!b_req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
            chk("b_rdy", 64'(b_req_ready), 64'd1);
            @(posedge clk);
            predict(1'b1, b_addr[k], b_wd[k], b_wr[k], b_be[k]);
            if (k > 0) chk("b_gap", 64'(b_gap), 64'(LAT_B + 1));
            b_gap = 0;
            #1;
            lat = 0;
            while (!b_resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            chk("b_lat", 64'(lat), 64'(LAT_B));
            exp = (sb_b.size() > 0) ? sb_b.pop_front() : 33'h1_FFFF_FFFF;
            chk("b_resp", {b_resp_err, b_resp_rdata}, exp);
        end
        b_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("b_final_rd", {1'b0, mem_b[16]}, {1'b0, 32'hAABB_5678});
        b_resp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire
